sparse_csr_stream_encoder: RTL
==============================

// Module: sparse_csr_stream_encoder
// PURPOSE
//  Streaming CSR encoder for one IMG_W x IMG_H frame of raster-order pixels. Keeps pixels above a
//  threshold; emits (value, col) element entries and one row-pointer entry per row through an
//  output FIFO with valid/ready backpressure. Sits between the input/feature-map source and the
//  sparse conv engine. Replaces the flat-bus encoder.
// PARAMETERS
//  DATA_W      8   pixel/value width
//  IDX_W       8   column index width; 2^IDX_W >= IMG_W
//  IMG_W      36   pixels per row
//  IMG_H      36   rows per frame
//  CNT_W      16   nnz/pixel counter width; 2^CNT_W > IMG_W*IMG_H
//  FIFO_DEPTH 16   output FIFO entries; power of two, >= 4
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       reset, asynchronous, active-high
//  thresh      in   DATA_W  keep pixel iff in_data > thresh (unsigned); sampled on frame's first beat
//  in_valid    in   1       input pixel valid
//  in_ready    out  1       encoder accepts pixel; beat transfers when in_valid && in_ready
//  in_data     in   DATA_W  pixel, raster order
//  out_valid   out  1       FIFO head valid
//  out_ready   in   1       consumer pops head when out_valid && out_ready
//  out_kind    out  1       0 = element entry, 1 = row-pointer entry
//  out_value   out  DATA_W  element value (0 when out_kind=1)
//  out_col     out  IDX_W   element column (0 when out_kind=1)
//  out_ptr     out  CNT_W   row pointer: cumulative nnz through end of this row (0 when out_kind=0)
//  frame_done  out  1       one-cycle pulse: frame fully encoded and drained
//  nnz_total   out  CNT_W   nnz of last completed frame; held until next frame_done
//  busy        out  1       state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, counters 0; in_ready=1, out_valid=0, out_kind/value/col/ptr=0,
//   frame_done=0, nnz_total=0, busy=0. Reset mid-frame discards partial frame and FIFO contents.
//  FSM: IDLE -(accepted beat)-> RUN -(last pixel accepted)-> FLUSH -(FIFO empty)-> DONE -> IDLE.
//   Single-pixel degenerate frame not supported (IMG_W*IMG_H >= 2).
//  in_ready = (state IDLE or RUN) && FIFO free slots >= 2. 0 in FLUSH and DONE.
//  Per accepted beat: col = pix_cnt mod IMG_W (column counter, no divider). If kept: push element
//   {in_data, col}, nnz += 1. If col == IMG_W-1: push row-pointer with out_ptr = nnz incl. this beat.
//   Element and row-pointer on same beat: both written same edge, element ahead of pointer.
//  Row pointers: exactly IMG_H per frame; leading CSR 0 implicit, not emitted.
//  Latency: entry written at edge N is visible at FIFO head from cycle after N if FIFO was empty.
//  FIFO: simultaneous push(1 or 2) and pop allowed; occupancy = occ + pushes - pop. Never overflows
//   (guaranteed by free>=2 rule); pop on empty impossible (out_valid=0).
//  DONE cycle: frame_done=1, nnz_total <= nnz; pix_cnt, col, nnz cleared for next frame.
//  Pixel counter and nnz wrap mod 2^CNT_W; parameter constraint forbids reaching wrap.
//  thresh changes mid-frame ignored (latched copy used).
// TESTING
//  T1 IMG_W=4,IMG_H=2,thresh=0,out_ready=1, pixels 0,5,0,7,0,0,0,0 -> E(5,c1),E(7,c3),P(2),P(2);
//     frame_done pulse, nnz_total=2.
//  T2 same params, all-zero frame -> P(0),P(0) only; nnz_total=0.
//  T3 thresh=3, pixels 3,4,9,2,0,3,255,1 -> E(4,c1),E(9,c2),P(2),E(255,c2),P(3); nnz_total=3.
//  T4 FIFO_DEPTH=4, out_ready=0, 8 pixels all 1 -> in_ready drops at free<2; then out_ready=1:
//     entries E(1,c0..c3),P(4),E(1,c0..c3),P(8) in order, none lost/duplicated.
//  T5 rst pulsed after 3 beats of a frame -> all outputs at reset values; next full frame encodes
//     as T1 with no residue from aborted frame.
//  T6 in_valid held high across frame end -> in_ready=0 in FLUSH/DONE; next frame starts at IDLE,
//     column 0, nnz from 0.

Source files
------------

// File: rtl/sparse_csr_stream_encoder.sv
// Streaming CSR encoder: thresholds raster pixels into (value, col) element
// entries plus one cumulative row-pointer entry per row, via an output FIFO.
module sparse_csr_stream_encoder #(
   parameter int DATA_W     = 8,
   parameter int IDX_W      = 8,
   parameter int IMG_W      = 36,
   parameter int IMG_H      = 36,
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] thresh,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_kind,
   output logic [DATA_W-1:0] out_value,
   output logic [IDX_W-1:0]  out_col,
   output logic [CNT_W-1:0]  out_ptr,
   output logic              frame_done,
   output logic [CNT_W-1:0]  nnz_total,
   output logic              busy
);

   localparam int TOTAL = IMG_W * IMG_H;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int EW    = 1 + DATA_W + IDX_W + CNT_W;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t state, state_n;

   logic [EW-1:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;

   logic [CNT_W-1:0]  pix_cnt, nnz, nnz_inc;
   logic [IDX_W-1:0]  col;
   logic [DATA_W-1:0] thr_q, thr_use;

   logic              accept, keep, eol, last, pop;
   logic [1:0]        n_push;
   logic [EW-1:0]     elem, rptr, ent_a, ent_b;

   logic              h_kind;
   logic [DATA_W-1:0] h_value;
   logic [IDX_W-1:0]  h_col;
   logic [CNT_W-1:0]  h_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (accept) state_n = RUN;
         RUN:     if (accept && last) state_n = FLUSH;
         FLUSH:   if (count == '0) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      in_ready   = (state == IDLE || state == RUN) &&
                   (count <= (AW+1)'(FIFO_DEPTH - 2));
      busy       = (state != IDLE);
      frame_done = (state == DONE);
   end

   // The first beat of a frame uses the live threshold; later beats the latched copy.
   assign accept  = in_valid && in_ready;
   assign thr_use = (state == IDLE) ? thresh : thr_q;
   assign keep    = accept && (in_data > thr_use);
   assign eol     = accept && (col == IDX_W'(IMG_W - 1));
   assign last    = (pix_cnt == CNT_W'(TOTAL - 1));
   assign nnz_inc = nnz + CNT_W'(keep);

   assign elem   = {1'b0, in_data, col, {CNT_W{1'b0}}};
   assign rptr   = {1'b1, {DATA_W{1'b0}}, {IDX_W{1'b0}}, nnz_inc};
   assign ent_a  = keep ? elem : rptr;
   assign ent_b  = rptr;
   assign n_push = {1'b0, keep} + {1'b0, eol};

   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;

   assign {h_kind, h_value, h_col, h_ptr} = mem[rd_ptr];
   assign out_kind  = out_valid & h_kind;
   assign out_value = out_valid ? h_value : '0;
   assign out_col   = out_valid ? h_col   : '0;
   assign out_ptr   = out_valid ? h_ptr   : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_cnt   <= '0;
         col       <= '0;
         nnz       <= '0;
         thr_q     <= '0;
         nnz_total <= '0;
      end else if (state == DONE) begin
         pix_cnt   <= '0;
         col       <= '0;
         nnz       <= '0;
         nnz_total <= nnz;
      end else if (accept) begin
         pix_cnt <= pix_cnt + 1'b1;
         col     <= eol ? '0 : col + 1'b1;
         nnz     <= nnz_inc;
         if (state == IDLE) thr_q <= thresh;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(n_push);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + (AW+1)'(n_push) - (AW+1)'(pop);
      end
   end

   // Element always lands ahead of its row pointer when both occur on one beat.
   always_ff @(posedge clk) begin
      if (n_push != 2'd0) mem[wr_ptr] <= ent_a;
      if (n_push == 2'd2) mem[wr_ptr + AW'(1)] <= ent_b;
   end

endmodule
